// File: rtl/ram_rd_pkg.sv
// rtl/ram_rd_pkg.sv - shared types and constants for the RAM stream reader
package ram_rd_pkg;

  // Command sequencing states of the reader
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_e;

  // Output buffer entries; also the cap on words in flight plus buffered
  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/rd_skid_fifo2.sv
// rtl/rd_skid_fifo2.sv - two-entry output buffer driving the m_valid/m_data stream
module rd_skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             pop,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign m_valid = !empty;
  assign m_data  = head_q;
  assign pop     = m_valid && m_ready;

  // Head is always the oldest word; a pop shifts the tail word forward
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams LEN words from RAM port B starting at BASE
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int ADDR  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDR-1:0]  base_addr,
  input  logic [ADDR:0]    len,
  output logic             busy,
  output logic             done,
  output logic             enb,
  output logic [ADDR-1:0]  addrb,
  input  logic [WIDTH-1:0] doutb,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  rd_state_e       state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR:0]   remaining_q, remaining_d;
  logic            inflight_q, inflight_d;
  logic [ADDR-1:0] addrb_q, addrb_d;
  logic            done_q, done_d;

  logic            issue;
  logic [ADDR-1:0] issue_addr;
  logic [2:0]      occupancy;
  logic            credit_ok;
  logic            buf_pop;
  logic [1:0]      buf_count;
  logic            buf_full;
  logic            buf_empty;

  function automatic logic [ADDR-1:0] next_addr(input logic [ADDR-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Read issue: the first read goes out in the start cycle; a pop in the same
  // cycle frees its slot, which keeps the stream bubble-free at m_ready=1
  always_comb begin
    issue_addr = (state_q == IDLE) ? base_addr : addr_q;
    occupancy  = 3'(inflight_q) + 3'(buf_count) - 3'(buf_pop);
    credit_ok  = (occupancy < 3'(RD_BUF_DEPTH)) && !buf_full;
    case (state_q)
      IDLE:    issue = start && (len != '0) && credit_ok;
      RUN:     issue = (remaining_q != '0) && credit_ok;
      default: issue = 1'b0;
    endcase
  end

  assign enb   = issue;
  assign addrb = issue ? issue_addr : addrb_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

  // Command sequencing, address walk with modulo-DEPTH wrap, remaining count
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
    addrb_d     = addrb;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = issue ? next_addr(base_addr) : base_addr;
          remaining_d = len - {{ADDR{1'b0}}, issue};
          if (len == '0)                        state_d = FIN;
          else if (len == {{ADDR{1'b0}}, 1'b1}) state_d = DRAIN;
          else                                  state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d      = next_addr(addr_q);
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{ADDR{1'b0}}, 1'b1}) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && buf_empty) state_d = FIN;
      end
      default: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      addrb_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      addrb_q     <= addrb_d;
      done_q      <= done_d;
    end
  end

  rd_skid_fifo2 #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (doutb),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .pop       (buf_pop),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

endmodule
